// File: rtl/hwpe_tcdm_flat_buffer_if.sv
// Bundled streamer-side (in_*) and interconnect-side (tcdm_*) TCDM signals of the flat buffer.
// The master modport is the buffer's own view; slave is the surrounding environment's view.
interface hwpe_tcdm_flat_buffer_if #(
  parameter int MP = 4,
  parameter int DW = 32,
  parameter int AW = 32
);
  localparam int BW = DW / 8;

  logic [MP-1:0]         in_req;
  logic [MP-1:0]         in_gnt;
  logic [MP-1:0][AW-1:0] in_add;
  logic [MP-1:0]         in_wen;
  logic [MP-1:0][BW-1:0] in_be;
  logic [MP-1:0][DW-1:0] in_data;
  logic [MP-1:0][DW-1:0] in_r_data;
  logic [MP-1:0]         in_r_valid;

  logic [MP-1:0]         tcdm_req;
  logic [MP-1:0]         tcdm_gnt;
  logic [MP-1:0][AW-1:0] tcdm_add;
  logic [MP-1:0]         tcdm_wen;
  logic [MP-1:0][BW-1:0] tcdm_be;
  logic [MP-1:0][DW-1:0] tcdm_data;
  logic [MP-1:0][DW-1:0] tcdm_r_data;
  logic [MP-1:0]         tcdm_r_valid;

  modport master (
    input  in_req, in_add, in_wen, in_be, in_data, tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    output in_gnt, in_r_data, in_r_valid, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );

  modport slave (
    output in_req, in_add, in_wen, in_be, in_data, tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    input  in_gnt, in_r_data, in_r_valid, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );
endinterface

// File: rtl/hwpe_tcdm_flat_buffer.sv
// Per-port request FIFO + outstanding limiter between HWPE streamer and TCDM interconnect.
// Define HWPE_TCDM_BUF_STATS_EN to build the per-port grant-stall counters.
module hwpe_tcdm_flat_buffer #(
  parameter int MP        = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int DEPTH     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  hwpe_tcdm_flat_buffer_if.master bus,
  output logic                   busy_o,
  output logic [MP-1:0]          err_o,
  output logic [MP-1:0][31:0]    stall_cnt_o
);
  localparam int BW = DW / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } entry_t;

  logic          flush;
  logic [MP-1:0] port_busy;

  assign flush  = rst_i || clear_i;
  assign busy_o = |port_busy;

  // Responses are passed straight through; ordering is guaranteed by the interconnect.
  assign bus.in_r_data  = bus.tcdm_r_data;
  assign bus.in_r_valid = bus.tcdm_r_valid;

  for (genvar gi = 0; gi < MP; gi++) begin : g_port
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [OW-1:0] outst_reg, outst_next;
    logic          err_reg, err_next;
    logic          full, empty, gnt, req, push, pop, rsp;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign gnt   = !full && !flush;
    // Once raised, req can only drop via a grant: the limiter only rises on a pop.
    assign req   = !empty && (outst_reg < OW'(MAX_OUTST)) && !flush;
    assign push  = bus.in_req[gi] && gnt;
    assign pop   = req && bus.tcdm_gnt[gi];
    assign rsp   = bus.tcdm_r_valid[gi];

    assign bus.in_gnt[gi]    = gnt;
    assign bus.tcdm_req[gi]  = req;
    assign head              = mem[rd_ptr_reg];
    assign bus.tcdm_add[gi]  = head.add;
    assign bus.tcdm_wen[gi]  = head.wen;
    assign bus.tcdm_be[gi]   = head.be;
    assign bus.tcdm_data[gi] = head.data;

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr_reg] <= '{add: bus.in_add[gi], wen: bus.in_wen[gi],
                             be: bus.in_be[gi], data: bus.in_data[gi]};
      end
    end

    always_comb begin
      count_next = count_reg;
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // A response with nothing outstanding is a protocol error and must not underflow.
    always_comb begin
      err_next   = err_reg;
      outst_next = outst_reg;
      if (rsp && (outst_reg == '0)) begin
        err_next = 1'b1;
      end
      if (pop && !(rsp && (outst_reg != '0))) begin
        outst_next = outst_reg + OW'(1);
      end else if (!pop && rsp && (outst_reg != '0)) begin
        outst_next = outst_reg - OW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        outst_reg  <= '0;
        err_reg    <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_next;
        outst_reg <= outst_next;
        err_reg   <= err_next;
      end
    end

    assign port_busy[gi] = !empty || (outst_reg != '0);
    assign err_o[gi]     = err_reg;

`ifdef HWPE_TCDM_BUF_STATS_EN
    logic [31:0] stall_reg;

    always_ff @(posedge clk_i) begin
      if (flush) begin
        stall_reg <= '0;
      end else if (req && !bus.tcdm_gnt[gi] && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end

    assign stall_cnt_o[gi] = stall_reg;
`else
    assign stall_cnt_o[gi] = '0;
`endif
  end
endmodule

// File: tb/tb_hwpe_tcdm_flat_buffer.sv
// Directed bench for hwpe_tcdm_flat_buffer: vector table for single/ordered transfers,
// hand sequences for reset, outstanding limit, protocol error and stall counting.
module tb_hwpe_tcdm_flat_buffer;
  localparam int MP = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NV = 15;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                clear_i;
  logic                busy_o;
  logic [MP-1:0]       err_o;
  logic [MP-1:0][31:0] stall_cnt_o;

  always #5 clk = ~clk;

  hwpe_tcdm_flat_buffer_if #(.MP(MP), .DW(DW), .AW(AW)) bus ();

  hwpe_tcdm_flat_buffer #(
    .MP(MP), .DW(DW), .AW(AW), .DEPTH(2), .MAX_OUTST(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    int          port;
    logic        req;
    logic [31:0] add;
    logic        tgnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_gnt;
    logic        e_req;
    logic [31:0] e_add;
    logic        e_busy;
  } vec_t;

  vec_t vecs [NV];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   issued;

  function automatic vec_t mk(input int p, input logic rq, input logic [31:0] a,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic eg, input logic er, input logic [31:0] ea,
                              input logic eb);
    vec_t v;
    v.port = p; v.req = rq; v.add = a; v.tgnt = g; v.rv = rv; v.rdata = rd;
    v.e_gnt = eg; v.e_req = er; v.e_add = ea; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_req       = '0;
    bus.in_add       = '0;
    bus.in_wen       = '0;
    bus.in_be        = '0;
    bus.in_data      = '0;
    bus.tcdm_gnt     = '0;
    bus.tcdm_r_valid = '0;
    bus.tcdm_r_data  = '0;
  endtask

  initial begin
    // T2: single read on p0; T3: three ordered pushes on p1 against a stalled grant
    vecs[0]  = mk(0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0);
    vecs[1]  = mk(0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b1);
    vecs[2]  = mk(0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,   1'b1);
    vecs[3]  = mk(0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0);
    vecs[4]  = mk(1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0);
    vecs[5]  = mk(1, 1'b1, 32'h204, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200, 1'b1);
    vecs[6]  = mk(1, 1'b1, 32'h208, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200, 1'b1);
    vecs[7]  = mk(1, 1'b1, 32'h208, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200, 1'b1);
    vecs[8]  = mk(1, 1'b1, 32'h208, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200, 1'b1);
    vecs[9]  = mk(1, 1'b1, 32'h208, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204, 1'b1);
    vecs[10] = mk(1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h208, 1'b1);
    vecs[11] = mk(1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1,        1'b1, 1'b0, 32'h0,   1'b1);
    vecs[12] = mk(1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h2,        1'b1, 1'b0, 32'h0,   1'b1);
    vecs[13] = mk(1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h3,        1'b1, 1'b0, 32'h0,   1'b1);
    vecs[14] = mk(1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0);

    idle();
    rst_i   = 1'b1;
    clear_i = 1'b0;

    // T1: reset held with every port requesting
    bus.in_req = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("t1_in_gnt",   32'(bus.in_gnt),   32'h0);
      chk("t1_tcdm_req", 32'(bus.tcdm_req), 32'h0);
      chk("t1_busy",     32'(busy_o),       32'h0);
      chk("t1_err",      32'(err_o),        32'h0);
      $display("[TB] reset cycle %0d gnt=%b req=%b", c, bus.in_gnt, bus.tcdm_req);
    end
    @(negedge clk);
    idle();
    rst_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      idle();
      bus.in_req[vecs[i].port]       = vecs[i].req;
      bus.in_add[vecs[i].port]       = vecs[i].add;
      bus.in_wen[vecs[i].port]       = 1'b1;
      bus.in_be[vecs[i].port]        = 4'hF;
      bus.in_data[vecs[i].port]      = ~vecs[i].add;
      bus.tcdm_gnt[vecs[i].port]     = vecs[i].tgnt;
      bus.tcdm_r_valid[vecs[i].port] = vecs[i].rv;
      bus.tcdm_r_data[vecs[i].port]  = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_in_gnt", i),   32'(bus.in_gnt[vecs[i].port]),   32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_tcdm_req", i), 32'(bus.tcdm_req[vecs[i].port]), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_busy", i),     32'(busy_o),                     32'(vecs[i].e_busy));
      chk($sformatf("v%0d_err", i),      32'(err_o),                      32'h0);
      chk($sformatf("v%0d_r_valid", i),  32'(bus.in_r_valid),
          32'(vecs[i].rv) << vecs[i].port);
      if (vecs[i].rv)
        chk($sformatf("v%0d_r_data", i), bus.in_r_data[vecs[i].port], vecs[i].rdata);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_tcdm_add", i),  bus.tcdm_add[vecs[i].port],  vecs[i].e_add);
        chk($sformatf("v%0d_tcdm_data", i), bus.tcdm_data[vecs[i].port], ~vecs[i].e_add);
        chk($sformatf("v%0d_tcdm_wen", i),  32'(bus.tcdm_wen[vecs[i].port]), 32'h1);
        chk($sformatf("v%0d_tcdm_be", i),   32'(bus.tcdm_be[vecs[i].port]),  32'hF);
      end
      $display("[TB] vec %0d p%0d req=%b add=%08h gnt=%b tcdm_req=%b tcdm_add=%08h",
               i, vecs[i].port, vecs[i].req, vecs[i].add, bus.in_gnt[vecs[i].port],
               bus.tcdm_req[vecs[i].port], bus.tcdm_add[vecs[i].port]);
    end

    // T4: outstanding limit on p0 with no responses
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
      bus.in_req[0]   = 1'b1;
      bus.in_add[0]   = 32'h1000 + 32'(c) * 4;
      bus.in_wen[0]   = 1'b1;
      bus.tcdm_gnt[0] = 1'b1;
      #1;
      if (bus.tcdm_req[0]) issued++;
    end
    chk("t4_issued", 32'(issued), 32'd4);
    $display("[TB] t4 issued %0d with no responses", issued);
    @(negedge clk);
    idle();
    bus.tcdm_gnt[0] = 1'b1;
    #1;
    chk("t4_req_low",   32'(bus.tcdm_req[0]), 32'h0);
    chk("t4_fifo_full", 32'(bus.in_gnt[0]),   32'h0);
    chk("t4_busy",      32'(busy_o),          32'h1);
    @(negedge clk);
    idle();
    bus.tcdm_gnt[0]     = 1'b1;
    bus.tcdm_r_valid[0] = 1'b1;
    #1;
    chk("t4_req_low_rsp", 32'(bus.tcdm_req[0]), 32'h0);
    issued = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle();
      bus.tcdm_gnt[0] = 1'b1;
      #1;
      if (bus.tcdm_req[0]) issued++;
    end
    chk("t4_issued_after_rsp", 32'(issued), 32'd1);
    $display("[TB] t4 issued %0d after one response", issued);
    @(negedge clk);
    idle();
    clear_i = 1'b1;
    #1;
    chk("t4_clear_gnt", 32'(bus.in_gnt),   32'h0);
    chk("t4_clear_req", 32'(bus.tcdm_req), 32'h0);
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    chk("t4_post_clear_busy", 32'(busy_o),     32'h0);
    chk("t4_post_clear_gnt",  32'(bus.in_gnt), 32'hF);

    // T5: unsolicited response on p2
    @(negedge clk);
    idle();
    bus.tcdm_r_valid[2] = 1'b1;
    bus.tcdm_r_data[2]  = 32'h55;
    #1;
    chk("t5_r_valid_pass", 32'(bus.in_r_valid), 32'h4);
    chk("t5_err_before",   32'(err_o),          32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("t5_err_sticky%0d", c), 32'(err_o),  32'h4);
      chk($sformatf("t5_busy%0d", c),       32'(busy_o), 32'h0);
    end
    $display("[TB] t5 err_o=%b after stray response", err_o);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    chk("t5_err_cleared", 32'(err_o), 32'h0);

    // T6: p3 stalled for 10 cycles
    @(negedge clk);
    idle();
    bus.in_req[3] = 1'b1;
    bus.in_add[3] = 32'h300;
    bus.in_wen[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("t6_req_held%0d", c), 32'(bus.tcdm_req[3]), 32'h1);
      chk($sformatf("t6_add_held%0d", c), bus.tcdm_add[3],      32'h300);
    end
    @(negedge clk);
    idle();
    bus.tcdm_gnt[3] = 1'b1;
    #1;
`ifdef HWPE_TCDM_BUF_STATS_EN
    chk("t6_stall_cnt", stall_cnt_o[3], 32'd10);
`else
    chk("t6_stall_cnt", stall_cnt_o[3], 32'd0);
`endif
    $display("[TB] t6 stall_cnt_o[3]=%0d", stall_cnt_o[3]);
    @(negedge clk);
    idle();
    #1;
`ifdef HWPE_TCDM_BUF_STATS_EN
    chk("t6_stall_hold", stall_cnt_o[3], 32'd10);
`else
    chk("t6_stall_hold", stall_cnt_o[3], 32'd0);
`endif
    chk("t6_busy_outst", 32'(busy_o),        32'h1);
    chk("t6_req_done",   32'(bus.tcdm_req),  32'h0);
    bus.tcdm_r_valid[3] = 1'b1;
    bus.tcdm_r_data[3]  = 32'hA5A5_0003;
    #1;
    chk("t6_r_data", bus.in_r_data[3], 32'hA5A5_0003);
    @(negedge clk);
    idle();
    #1;
    chk("t6_idle_busy", 32'(busy_o), 32'h0);
    chk("t6_idle_err",  32'(err_o),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
